and_self_test: RTL and testbench

AND_SELF_TEST -- requirements
Module: and_self_test

---
 rtl/and_test_pkg.sv | 20 ++
 rtl/and_self_test_if.sv | 22 ++
 rtl/and_self_test_dwell_timer.sv | 30 +++
 rtl/example_and.sv | 8 +
 rtl/and_self_test.sv | 94 +++++++++
 tb/tb_and_self_test.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/and_test_pkg.sv
// Shared definitions for the AND-gate self-test: FSM encoding and the stimulus table.
package and_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  // {input_1,input_2} per index; element 0 is the rightmost entry.
  localparam logic [NUM_VECTORS-1:0][1:0] VEC_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic vec_expected(input logic [1:0] v);
    return v[1] & v[0];
  endfunction

endpackage

// File: rtl/and_self_test_if.sv
// Signal bundle between the self-test controller and its host / gate under test.
interface and_self_test_if;
  logic       start;
  logic       input_1;
  logic       input_2;
  logic       and_result;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] error_count;
  logic [1:0] first_fail;

  modport master (
    output start, and_result,
    input  input_1, input_2, busy, done, pass, error_count, first_fail
  );

  modport slave (
    input  start, and_result,
    output input_1, input_2, busy, done, pass, error_count, first_fail
  );
endinterface

// File: rtl/and_self_test_dwell_timer.sv
// Down-counter that flags the last cycle of a DWELL_CYCLES-long hold window.
module dwell_timer #(
  parameter int DWELL_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done_pulse
);
  localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          run;

  // run gates the pulse so a parked zero count does not keep firing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= CW'(DWELL_CYCLES - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - CW'(1);
    end
  end

  assign done_pulse = run && (cnt == '0);
endmodule

// File: rtl/example_and.sv
// Reference two-input AND gate used as the device under self-test.
module example_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/and_self_test.sv
// Self-test controller: walks four vectors through an AND gate and scores the responses.
module and_self_test
  import and_test_pkg::*;
#(
  parameter int DWELL_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  and_self_test_if.slave   sif
);

  state_t     state, state_nx;
  logic [1:0] idx;
  logic [2:0] err_cnt;
  logic [1:0] ffail;
  logic       in_a, in_b;
  logic       load;
  logic       tmr_done;
  logic       mismatch;

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .done_pulse (tmr_done)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE, DONE: if (sif.start) begin
        state_nx = APPLY;
        load     = 1'b1;
      end
      APPLY: if (tmr_done) state_nx = CHECK;
      CHECK: begin
        if (idx == 2'(NUM_VECTORS - 1)) begin
          state_nx = DONE;
        end else begin
          state_nx = APPLY;
          load     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mismatch = (sif.and_result != vec_expected(VEC_TABLE[idx]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      err_cnt <= '0;
      ffail   <= '0;
      in_a    <= 1'b0;
      in_b    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: if (sif.start) begin
          idx          <= '0;
          err_cnt      <= '0;
          ffail        <= '0;
          {in_a, in_b} <= VEC_TABLE[0];
        end
        CHECK: begin
          // vector is still driven here, so the response belongs to idx
          if (mismatch) begin
            if (err_cnt != 3'd4) err_cnt <= err_cnt + 3'd1;
            if (err_cnt == 3'd0) ffail   <= idx;
          end
          if (idx == 2'(NUM_VECTORS - 1)) begin
            {in_a, in_b} <= 2'b00;
          end else begin
            idx          <= idx + 2'd1;
            {in_a, in_b} <= VEC_TABLE[idx + 2'd1];
          end
        end
        default: ;
      endcase
    end
  end

  assign sif.input_1     = in_a;
  assign sif.input_2     = in_b;
  assign sif.busy        = (state == APPLY) || (state == CHECK);
  assign sif.done        = (state == DONE);
  assign sif.pass        = (state == DONE) && (err_cnt == 3'd0);
  assign sif.error_count = err_cnt;
  assign sif.first_fail  = ffail;

endmodule

// File: tb/tb_and_self_test.sv
// Scoreboard bench: stimulus queues expected run results, monitors score them when done rises.
module tb_and_self_test;

  typedef struct packed {
    int         start_edge;
    int         lat;
    logic [2:0] err;
    logic [1:0] ff;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   fault = 0;   // 0 good gate, 1 stuck-at-0, 2 stuck-at-1
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;
  logic y_a, y_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  and_self_test_if a_if();
  and_self_test_if b_if();

  and_self_test #(.DWELL_CYCLES(10)) dut_a (.clk(clk), .rst(rst), .sif(a_if.slave));
  and_self_test #(.DWELL_CYCLES(2))  dut_b (.clk(clk), .rst(rst), .sif(b_if.slave));

  example_and g_a (.a(a_if.input_1), .b(a_if.input_2), .y(y_a));
  example_and g_b (.a(b_if.input_1), .b(b_if.input_2), .y(y_b));

  assign a_if.and_result = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : y_a;
  assign b_if.and_result = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : y_b;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pulse(input int u, output int se);
    @(negedge clk);
    se = cyc + 1;
    if (u == 0) a_if.start = 1'b1;
    else        b_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    b_if.start = 1'b0;
  endtask

  task automatic push(input int u, input int se, input int lat, input int err,
                      input int ff, input int ps);
    exp_t e;
    e.start_edge = se;
    e.lat        = lat;
    e.err        = 3'(err);
    e.ff         = 2'(ff);
    e.ps         = ps[0];
    if (u == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d runs outstanding expected 0", q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitors: score a completed run on the rising edge of done
  always @(negedge clk) begin
    exp_t e;
    if (a_if.done && !done_a_q) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_latency",     cyc - e.start_edge, e.lat);
        chk("a_error_count", a_if.error_count, e.err);
        chk("a_first_fail",  a_if.first_fail, e.ff);
        chk("a_pass",        a_if.pass, e.ps);
        chk("a_done_idle",   {a_if.busy, a_if.input_1, a_if.input_2}, 0);
      end
    end
    done_a_q = a_if.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_if.done && !done_b_q) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_latency",     cyc - e.start_edge, e.lat);
        chk("b_error_count", b_if.error_count, e.err);
        chk("b_first_fail",  b_if.first_fail, e.ff);
        chk("b_pass",        b_if.pass, e.ps);
        chk("b_done_idle",   {b_if.busy, b_if.input_1, b_if.input_2}, 0);
      end
    end
    done_b_q = b_if.done;
  end

  function automatic int outs_a();
    return int'({a_if.input_1, a_if.input_2, a_if.busy, a_if.done, a_if.pass,
                 a_if.error_count, a_if.first_fail});
  endfunction

  initial begin
    int se;
    logic [1:0] hold_exp [12] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10,
                                  2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("a_reset_outputs", outs_a(), 0);
    chk("b_reset_outputs", int'({b_if.input_1, b_if.input_2, b_if.busy, b_if.done,
                                 b_if.pass, b_if.error_count, b_if.first_fail}), 0);

    // good gate
    fault = 0;
    pulse(0, se);
    push(0, se, 44, 0, 0, 1);
    chk("a_busy_after_start", {a_if.busy, a_if.done, a_if.input_1, a_if.input_2}, 4'b1000);
    drain(100);
    repeat (3) @(negedge clk);
    chk("a_done_held", {a_if.done, a_if.pass}, 2'b11);

    // stuck-at-0 then stuck-at-1, each started from DONE
    fault = 1;
    pulse(0, se);
    push(0, se, 44, 1, 2, 0);
    drain(100);
    fault = 2;
    pulse(0, se);
    push(0, se, 44, 3, 0, 0);
    drain(100);

    // restart from DONE must clear results; extra start at clock 15 is ignored
    fault = 0;
    pulse(0, se);
    push(0, se, 44, 0, 0, 1);
    chk("a_start_clears", {a_if.busy, a_if.done, a_if.error_count, a_if.first_fail}, 7'b1000000);
    while (cyc < se + 14) @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    drain(100);

    // abort during index 2 with start held alongside rst
    fault = 2;
    pulse(0, se);
    while (cyc < se + 24) @(negedge clk);
    chk("a_mid_run_vector", {a_if.busy, a_if.input_1, a_if.input_2}, 3'b111);
    rst = 1'b1;
    a_if.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_if.start = 1'b0;
    chk("a_abort_outputs", outs_a(), 0);
    repeat (3) @(negedge clk);
    chk("a_abort_stays_idle", outs_a(), 0);
    fault = 0;
    pulse(0, se);
    push(0, se, 44, 0, 0, 1);
    drain(100);

    // short dwell: vector hold pattern and 12-clock completion
    pulse(1, se);
    push(1, se, 12, 0, 0, 1);
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("b_hold_%0d", j), {b_if.input_1, b_if.input_2}, hold_exp[j]);
      @(negedge clk);
    end
    drain(40);
    fault = 1;
    pulse(1, se);
    push(1, se, 12, 1, 2, 0);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
